mips_bus_arbiter: RTL and testbench

Two-port arbiter that shares the single memory bus of the pipelined MIPS CPU between the instruction-fetch port (IF stage) and the data port (MEM stage). It sits between the pipeline and the external memory interface (address/read/write/writedata/byteenable/readdata/waitrequest). It holds the grant across waitrequest stalls, returns read data and a one-cycle acknowledge to the winning port, and applies data-first priority with a starvation guard for instruction fetch.

---
 rtl/mips_bus_pkg.sv | 18 +
 rtl/mips_bus_arbiter.sv | 105 ++++++++++
 tb/tb_mips_bus_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_bus_pkg.sv
// rtl/mips_bus_pkg.sv - shared constants and types for the MIPS bus arbiter
package mips_bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_I    = 2'b01;
    localparam logic [1:0] GNT_D    = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LOCK_I = 2'b01,
        ST_LOCK_D = 2'b10
    } arb_state_t;

endpackage

// File: rtl/mips_bus_arbiter.sv
// rtl/mips_bus_arbiter.sv - data-first IF/MEM bus arbiter with fetch starvation guard
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [BE_W-1:0]   d_byteenable,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic [ADDR_W-1:0] address,
    output logic              read,
    output logic              write,
    output logic [DATA_W-1:0] writedata,
    output logic [BE_W-1:0]   byteenable,
    input  logic [DATA_W-1:0] readdata,
    input  logic              waitrequest,
    output logic [1:0]        grant
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_t       state;
    logic [CNT_W-1:0] starve_cnt;
    logic [1:0]       win;
    logic             d_req;
    logic             accept;

    assign d_req = d_read | d_write;

    // Winner is gated by reset so the bus goes quiet the instant reset asserts.
    always_comb begin
        win = GNT_NONE;
        if (reset) begin
            case (state)
                ST_IDLE: begin
                    if (i_req && (starve_cnt == CNT_MAX || !d_req))
                        win = GNT_I;
                    else if (d_req)
                        win = GNT_D;
                end
                ST_LOCK_I: if (i_req) win = GNT_I;
                ST_LOCK_D: if (d_req) win = GNT_D;
                default:   win = GNT_NONE;
            endcase
        end
    end

    always_comb begin
        address    = '0;
        read       = 1'b0;
        write      = 1'b0;
        writedata  = '0;
        byteenable = '0;
        if (win == GNT_I) begin
            address    = i_addr;
            read       = 1'b1;
            byteenable = {BE_W{1'b1}};
        end else if (win == GNT_D) begin
            address    = d_addr;
            writedata  = d_wdata;
            byteenable = d_byteenable;
            write      = d_write;
            read       = !d_write;
        end
    end

    assign accept  = (win != GNT_NONE) && !waitrequest;
    assign i_ack   = accept && (win == GNT_I);
    assign d_ack   = accept && (win == GNT_D);
    assign i_rdata = readdata;
    assign d_rdata = readdata;
    assign grant   = win;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            starve_cnt <= '0;
        end else begin
            // A dropped request while locked also lands here: abort back to IDLE.
            if (win == GNT_NONE || accept)
                state <= ST_IDLE;
            else if (win == GNT_I)
                state <= ST_LOCK_I;
            else
                state <= ST_LOCK_D;

            if (!i_req || i_ack)
                starve_cnt <= '0;
            else if (starve_cnt != CNT_MAX)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// tb/tb_mips_bus_arbiter.sv - directed and randomized scoreboard bench for mips_bus_arbiter
module tb_mips_bus_arbiter;
    import mips_bus_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        d_read, d_write;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_byteenable;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic [31:0] address;
    logic        read, write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        waitrequest;
    logic [1:0]  grant;

    mips_bus_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_byteenable(d_byteenable), .d_rdata(d_rdata), .d_ack(d_ack),
        .address(address), .read(read), .write(write), .writedata(writedata),
        .byteenable(byteenable), .readdata(readdata), .waitrequest(waitrequest),
        .grant(grant)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        is_write;
    } txn_t;

    txn_t i_q[$];
    txn_t d_q[$];

    int          errors = 0;
    int          checks = 0;
    logic        dir_mode = 1'b1;
    logic        mon_en = 1'b0;
    logic [31:0] dir_rdata = '0;
    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];

    function automatic logic [31:0] init_word(int k);
        return (32'(k) * 32'h0100_0193) ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always_comb readdata = dir_mode ? dir_rdata : mem[address[9:2]];

    // Memory environment: commits accepted writes with byte-lane merge.
    initial begin
        for (int k = 0; k < 256; k++) mem[k] = init_word(k);
        forever begin
            @(negedge clk);
            if (!dir_mode && write && !waitrequest)
                mem[address[9:2]] = merge(mem[address[9:2]], writedata, byteenable);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!dir_mode) waitrequest = ($urandom_range(0, 3) == 0);
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (mon_en) begin
            if (i_ack && d_ack) check("dual_ack", 32'(i_ack & d_ack), 32'd0);
            if (i_ack) begin
                if (i_q.size() == 0) check("i_ack_unexpected", 32'(i_q.size()), 32'd1);
                else begin
                    txn_t e;
                    e = i_q.pop_front();
                    check("rand_i_addr", address, e.addr);
                    check("rand_i_rdata", i_rdata, e.data);
                    check("rand_i_grant", 32'(grant), 32'(GNT_I));
                    check("rand_i_be", 32'(byteenable), 32'hF);
                end
            end
            if (d_ack) begin
                if (d_q.size() == 0) check("d_ack_unexpected", 32'(d_q.size()), 32'd1);
                else begin
                    txn_t e;
                    e = d_q.pop_front();
                    check("rand_d_addr", address, e.addr);
                    check("rand_d_write", 32'(write), 32'(e.is_write));
                    check("rand_d_read", 32'(read), 32'(!e.is_write));
                    check("rand_d_be", 32'(byteenable), 32'(e.be));
                    check("rand_d_grant", 32'(grant), 32'(GNT_D));
                    if (e.is_write) check("rand_d_wdata", writedata, e.wdata);
                    else            check("rand_d_rdata", d_rdata, e.data);
                end
            end
        end
    end

    task automatic i_driver(int n);
        for (int t = 0; t < n; t++) begin
            txn_t e;
            int   budget;
            int   idx;
            idx    = int'($urandom_range(0, 127));
            e.addr = 32'(idx) << 2;
            e.data = init_word(idx);
            e.wdata = '0;
            e.be = 4'hF;
            e.is_write = 1'b0;
            i_q.push_back(e);
            i_addr = e.addr;
            i_req  = 1'b1;
            budget = 0;
            do begin
                @(negedge clk);
                budget++;
            end while (!i_ack && budget < 300);
            if (!i_ack) check("i_timeout", 32'(budget), 32'd0);
            step();
            begin
                int k;
                k = int'($urandom_range(0, 2));
                if (k > 0) begin
                    i_req = 1'b0;
                    repeat (k) step();
                end
            end
        end
        i_req = 1'b0;
    endtask

    task automatic d_driver(int n);
        for (int t = 0; t < n; t++) begin
            txn_t e;
            int   budget;
            int   idx;
            int   op;
            idx   = 128 + int'($urandom_range(0, 127));
            op    = int'($urandom_range(0, 2));
            e.addr  = 32'(idx) << 2;
            e.wdata = $urandom;
            e.be    = 4'($urandom_range(0, 15));
            e.is_write = (op != 0);
            if (e.is_write) begin
                ref_mem[idx] = merge(ref_mem[idx], e.wdata, e.be);
                e.data = '0;
            end else begin
                e.data = ref_mem[idx];
            end
            d_q.push_back(e);
            d_addr       = e.addr;
            d_wdata      = e.wdata;
            d_byteenable = e.be;
            d_read       = (op != 1);
            d_write      = (op != 0);
            budget = 0;
            do begin
                @(negedge clk);
                budget++;
            end while (!d_ack && budget < 300);
            if (!d_ack) check("d_timeout", 32'(budget), 32'd0);
            step();
            begin
                int k;
                k = int'($urandom_range(0, 2));
                if (k > 0) begin
                    d_read = 1'b0;
                    d_write = 1'b0;
                    repeat (k) step();
                end
            end
        end
        d_read  = 1'b0;
        d_write = 1'b0;
    endtask

    initial begin
        reset = 1'b0; i_req = 1'b0; i_addr = '0;
        d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0; d_byteenable = '0;
        waitrequest = 1'b0;
        for (int k = 0; k < 256; k++) ref_mem[k] = init_word(k);

        // Reset holds the bus quiet regardless of requests.
        repeat (2) step();
        i_req = 1'b1; d_write = 1'b1; d_addr = 32'h0000_0400;
        d_wdata = 32'h1234_5678; d_byteenable = 4'hF;
        @(negedge clk);
        check("rst_read", 32'(read), 32'd0);
        check("rst_write", 32'(write), 32'd0);
        check("rst_grant", 32'(grant), 32'(GNT_NONE));
        check("rst_i_ack", 32'(i_ack), 32'd0);
        check("rst_d_ack", 32'(d_ack), 32'd0);
        check("rst_address", address, 32'd0);
        step();
        reset = 1'b1;
        @(negedge clk);
        check("rel_grant", 32'(grant), 32'(GNT_D));
        check("rel_write", 32'(write), 32'd1);
        check("rel_d_ack", 32'(d_ack), 32'd1);
        step();
        i_req = 1'b0; d_write = 1'b0;
        step();

        // Single zero-wait fetch.
        i_req = 1'b1; i_addr = 32'h0000_0010; dir_rdata = 32'h2402_0005;
        @(negedge clk);
        check("fetch_read", 32'(read), 32'd1);
        check("fetch_be", 32'(byteenable), 32'hF);
        check("fetch_ack", 32'(i_ack), 32'd1);
        check("fetch_rdata", i_rdata, 32'h2402_0005);
        check("fetch_grant", 32'(grant), 32'(GNT_I));
        check("fetch_addr", address, 32'h0000_0010);
        step();
        i_req = 1'b0;

        // Write with three wait cycles; fetch arrives mid-lock and must wait.
        d_write = 1'b1; d_addr = 32'h0000_0400; d_wdata = 32'hDEAD_BEEF;
        d_byteenable = 4'b0011; waitrequest = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin i_req = 1'b1; i_addr = 32'h0000_0020; end
            if (k == 3) waitrequest = 1'b0;
            @(negedge clk);
            check("wr_write", 32'(write), 32'd1);
            check("wr_addr", address, 32'h0000_0400);
            check("wr_wdata", writedata, 32'hDEAD_BEEF);
            check("wr_be", 32'(byteenable), 32'h3);
            check("wr_grant", 32'(grant), 32'(GNT_D));
            check("wr_d_ack", 32'(d_ack), 32'(k == 3));
            check("wr_i_ack", 32'(i_ack), 32'd0);
            step();
        end
        d_write = 1'b0; dir_rdata = 32'h8C01_0000;
        @(negedge clk);
        check("cont_i_ack", 32'(i_ack), 32'd1);
        check("cont_i_addr", address, 32'h0000_0020);
        check("cont_i_rdata", i_rdata, 32'h8C01_0000);
        step();
        i_req = 1'b0;
        step();

        // Starvation: four data wins, then fetch, then data again.
        i_req = 1'b1; i_addr = 32'h0000_0030; d_read = 1'b1; d_addr = 32'h0000_0404;
        d_byteenable = 4'hF;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("starve_d_ack", 32'(d_ack), 32'(k != 4));
            check("starve_i_ack", 32'(i_ack), 32'(k == 4));
            step();
        end
        i_req = 1'b0; d_read = 1'b0;
        step();

        // Abort of a locked data read; pending fetch wins next.
        d_read = 1'b1; waitrequest = 1'b1;
        @(negedge clk);
        check("abort_lock_grant", 32'(grant), 32'(GNT_D));
        check("abort_lock_read", 32'(read), 32'd1);
        check("abort_lock_ack", 32'(d_ack), 32'd0);
        step();
        d_read = 1'b0; i_req = 1'b1;
        @(negedge clk);
        check("abort_read", 32'(read), 32'd0);
        check("abort_grant", 32'(grant), 32'(GNT_NONE));
        check("abort_i_ack", 32'(i_ack), 32'd0);
        check("abort_d_ack", 32'(d_ack), 32'd0);
        step();
        waitrequest = 1'b0;
        @(negedge clk);
        check("post_abort_i_ack", 32'(i_ack), 32'd1);
        check("post_abort_grant", 32'(grant), 32'(GNT_I));
        step();
        i_req = 1'b0;

        // Read and write together resolve to a write.
        d_read = 1'b1; d_write = 1'b1;
        @(negedge clk);
        check("rw_write", 32'(write), 32'd1);
        check("rw_read", 32'(read), 32'd0);
        check("rw_ack", 32'(d_ack), 32'd1);
        step();
        d_write = 1'b0;

        // Reset mid-transfer drops strobes at once; transfer restarts after release.
        waitrequest = 1'b1;
        @(negedge clk);
        check("mid_read", 32'(read), 32'd1);
        #1 reset = 1'b0;
        #1;
        check("mid_rst_read", 32'(read), 32'd0);
        check("mid_rst_grant", 32'(grant), 32'(GNT_NONE));
        check("mid_rst_ack", 32'(d_ack), 32'd0);
        step();
        reset = 1'b1; waitrequest = 1'b0;
        @(negedge clk);
        check("restart_d_ack", 32'(d_ack), 32'd1);
        step();
        d_read = 1'b0;
        step();

        // Randomized concurrent traffic against the scoreboard.
        dir_mode = 1'b0;
        mon_en   = 1'b1;
        fork
            i_driver(150);
            d_driver(150);
        join
        repeat (3) step();
        check("i_q_drained", 32'(i_q.size()), 32'd0);
        check("d_q_drained", 32'(d_q.size()), 32'd0);
        mon_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
